// File: rtl/mult_display_controller.sv
// ---------------------------------------------------------------------------
// mult_display_controller
//
// Drives the 3-bit input of the seven-segment encoder attached to the 8x8
// sequential multiplier. While a multiplication runs it shows the step
// counter (codes 0..3). After completion it blinks the final step, then
// blanks the display after a hold period. A step count that does not advance
// by exactly one (mod 4) latches an error code until the next start.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset_a  in   1  asynchronous active-low reset
//   start    in   1  begins or restarts a run (highest priority)
//   step_en  in   1  multiplier advanced its step counter this cycle
//   count    in   2  multiplier step counter, valid with step_en
//   done     in   1  multiplier completion flag (lowest priority)
//   seg_sel  out  3  code for the seven-segment encoder
//   busy     out  1  high while a run is in progress
//   err      out  1  high while the error code is latched
//   state_o  out  2  FSM state: IDLE=0, RUN=1, DONE=2, ERR=3
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module mult_display_controller #(
  parameter int         BLINK_DIV   = 4,
  parameter int         HOLD_CYCLES = 16,
  parameter logic [2:0] BLANK_CODE  = 3'b100,
  parameter logic [2:0] ERR_CODE    = 3'b111
) (
  input  logic       clk,
  input  logic       reset_a,
  input  logic       start,
  input  logic       step_en,
  input  logic [1:0] count,
  input  logic       done,
  output logic [2:0] seg_sel,
  output logic       busy,
  output logic       err,
  output logic [1:0] state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  // A parameter of 1 would give $clog2 = 0; keep at least one bit.
  localparam int BLINK_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

  logic [1:0]         state_q,    state_d;
  logic [2:0]         seg_sel_q,  seg_sel_d;
  logic               busy_q,     busy_d;
  logic               err_q,      err_d;
  logic [1:0]         last_cnt_q, last_cnt_d;
  logic [BLINK_W-1:0] blink_q,    blink_d;
  logic [HOLD_W-1:0]  hold_q,     hold_d;
  logic               phase_q,    phase_d;   // 1 = digit visible

  // Expected next step value; the 2-bit add wraps 3 -> 0 naturally.
  logic [1:0] next_cnt;
  logic       step_ok;

  assign next_cnt = last_cnt_q + 2'd1;
  assign step_ok  = (count == next_cnt);

  always_comb begin
    state_d    = state_q;
    seg_sel_d  = seg_sel_q;
    last_cnt_d = last_cnt_q;
    blink_d    = blink_q;
    hold_d     = hold_q;
    phase_d    = phase_q;

    if (start) begin
      // Start wins in every state, including a restart from RUN.
      state_d    = S_RUN;
      seg_sel_d  = 3'b000;
      last_cnt_d = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          seg_sel_d = BLANK_CODE;
        end

        S_RUN: begin
          if (step_en) begin
            if (step_ok) begin
              last_cnt_d = count;
              seg_sel_d  = {1'b0, count};
              // A valid final step arriving together with done is shown
              // as the completed value.
              if (done) begin
                state_d = S_DONE;
                blink_d = '0;
                hold_d  = '0;
                phase_d = 1'b1;
              end
            end else begin
              state_d   = S_ERR;
              seg_sel_d = ERR_CODE;
            end
          end else if (done) begin
            state_d   = S_DONE;
            seg_sel_d = {1'b0, last_cnt_q};
            blink_d   = '0;
            hold_d    = '0;
            phase_d   = 1'b1;
          end
        end

        S_DONE: begin
          if (hold_q == HOLD_LAST) begin
            state_d   = S_IDLE;
            seg_sel_d = BLANK_CODE;
            blink_d   = '0;
            hold_d    = '0;
            phase_d   = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_ONE;
            if (blink_q == BLINK_LAST) begin
              blink_d   = '0;
              phase_d   = ~phase_q;
              seg_sel_d = phase_q ? BLANK_CODE : {1'b0, last_cnt_q};
            end else begin
              blink_d   = blink_q + BLINK_ONE;
              seg_sel_d = phase_q ? {1'b0, last_cnt_q} : BLANK_CODE;
            end
          end
        end

        S_ERR: begin
          seg_sel_d = ERR_CODE;
        end

        default: begin
          state_d   = S_IDLE;
          seg_sel_d = BLANK_CODE;
        end
      endcase
    end

    // Status flags are registered copies of the next state.
    busy_d = (state_d == S_RUN);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q    <= S_IDLE;
      seg_sel_q  <= BLANK_CODE;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      last_cnt_q <= 2'd0;
      blink_q    <= '0;
      hold_q     <= '0;
      phase_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      seg_sel_q  <= seg_sel_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      last_cnt_q <= last_cnt_d;
      blink_q    <= blink_d;
      hold_q     <= hold_d;
      phase_q    <= phase_d;
    end
  end

  assign seg_sel = seg_sel_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mult_display_controller.sv
// ---------------------------------------------------------------------------
// tb_mult_display_controller
//
// Each scenario task applies one stimulus vector per clock and pushes the
// output expected one clock later into a queue; the same task pops it after
// the edge and compares it against {seg_sel, state_o, busy, err}.
// Stimulus vector layout: {start, step_en, count[1:0], done}.
// ---------------------------------------------------------------------------
module tb_mult_display_controller;

  logic       clk;
  logic       reset_a;
  logic       start;
  logic       step_en;
  logic [1:0] count;
  logic       done;
  logic [2:0] seg_sel;
  logic       busy;
  logic       err;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] exp_q [$];

  localparam logic [4:0] NONE   = 5'b00000;
  localparam logic [4:0] START  = 5'b10000;
  localparam logic [4:0] DONE_I = 5'b00001;
  localparam logic [4:0] S0     = 5'b01000;
  localparam logic [4:0] S1     = 5'b01010;
  localparam logic [4:0] S2     = 5'b01100;
  localparam logic [4:0] S3     = 5'b01110;

  mult_display_controller dut (
    .clk     (clk),
    .reset_a (reset_a),
    .start   (start),
    .step_en (step_en),
    .count   (count),
    .done    (done),
    .seg_sel (seg_sel),
    .busy    (busy),
    .err     (err),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observation: busy only in RUN, err only in ERR.
  function automatic logic [6:0] e(input logic [2:0] s, input logic [1:0] st);
    return {s, st, (st == 2'd1), (st == 2'd3)};
  endfunction

  task automatic drive(input logic [4:0] s, input logic [6:0] x);
    {start, step_en, count, done} = s;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    logic [6:0] xp;
    logic [4:0] st [4];
    logic [6:0] ex [4];
    reset_a = 1'b1;
    {start, step_en, count, done} = NONE;
    #2 reset_a = 1'b0;
    #1;
    got = {seg_sel, state_o, busy, err};
    n_checks++;
    if (got !== e(3'b100, 2'd0)) begin
      n_fail++;
      $display("FAIL reset_initial got=%b exp=%b", got, e(3'b100, 2'd0));
    end
    @(posedge clk); #1;
    reset_a = 1'b1;
    // Run briefly, then reset asynchronously mid-cycle.
    st = '{START, S1, S2, S1 | 5'b00001};
    ex = '{e(3'd0, 2'd1), e(3'd1, 2'd1), e(3'd2, 2'd1), e(3'd1, 2'd2)};
    for (int i = 0; i < 3; i++) begin
      drive(st[i], ex[i]);
      xp  = exp_q.pop_front();
      got = {seg_sel, state_o, busy, err};
      n_checks++;
      if (got !== xp) begin
        n_fail++;
        $display("FAIL reset_run[%0d] got=%b exp=%b", i, got, xp);
      end
    end
    {start, step_en, count, done} = S3;
    #2 reset_a = 1'b0;
    #1;
    got = {seg_sel, state_o, busy, err};
    n_checks++;
    if (got !== e(3'b100, 2'd0)) begin
      n_fail++;
      $display("FAIL reset_async got=%b exp=%b", got, e(3'b100, 2'd0));
    end
    {start, step_en, count, done} = START;
    @(posedge clk); #1;
    @(posedge clk); #1;
    got = {seg_sel, state_o, busy, err};
    n_checks++;
    if (got !== e(3'b100, 2'd0)) begin
      n_fail++;
      $display("FAIL reset_held got=%b exp=%b", got, e(3'b100, 2'd0));
    end
    reset_a = 1'b1;
    // IDLE ignores step_en and done.
    st = '{S1 | 5'b00001, DONE_I, S0, NONE};
    ex = '{e(3'b100, 2'd0), e(3'b100, 2'd0), e(3'b100, 2'd0), e(3'b100, 2'd0)};
    for (int i = 0; i < 4; i++) begin
      drive(st[i], ex[i]);
      xp  = exp_q.pop_front();
      got = {seg_sel, state_o, busy, err};
      n_checks++;
      if (got !== xp) begin
        n_fail++;
        $display("FAIL reset_idle[%0d] got=%b exp=%b", i, got, xp);
      end
    end
  endtask

  task automatic test_normal_run();
    logic [6:0] got;
    logic [6:0] xp;
    logic [4:0] st [5];
    logic [6:0] ex [5];
    st = '{START, S1, S2, S3, DONE_I};
    ex = '{e(3'd0, 2'd1), e(3'd1, 2'd1), e(3'd2, 2'd1), e(3'd3, 2'd1),
           e(3'd3, 2'd2)};
    for (int i = 0; i < 5; i++) begin
      drive(st[i], ex[i]);
      xp  = exp_q.pop_front();
      got = {seg_sel, state_o, busy, err};
      n_checks++;
      if (got !== xp) begin
        n_fail++;
        $display("FAIL normal_run[%0d] got=%b exp=%b", i, got, xp);
      end
    end
  endtask

  // Continues from the first DONE cycle left by test_normal_run.
  task automatic test_blink_timeout();
    logic [6:0] got;
    logic [6:0] xp;
    logic [6:0] x;
    for (int i = 1; i <= 18; i++) begin
      if (i >= 16)
        x = e(3'b100, 2'd0);
      else if (((i / 4) % 2) == 0)
        x = e(3'd3, 2'd2);
      else
        x = e(3'b100, 2'd2);
      // Odd cycles inject step_en/done, which DONE and IDLE must ignore.
      drive((i % 2 == 1) ? (S0 | 5'b00001) : NONE, x);
      xp  = exp_q.pop_front();
      got = {seg_sel, state_o, busy, err};
      n_checks++;
      if (got !== xp) begin
        n_fail++;
        $display("FAIL blink_timeout[%0d] got=%b exp=%b", i, got, xp);
      end
    end
  endtask

  task automatic test_out_of_order();
    logic [6:0] got;
    logic [6:0] xp;
    logic [4:0] st [8];
    logic [6:0] ex [8];
    st = '{START, S1, S3, S2, DONE_I, S0 | 5'b00001, START, S1};
    ex = '{e(3'd0, 2'd1), e(3'd1, 2'd1), e(3'b111, 2'd3), e(3'b111, 2'd3),
           e(3'b111, 2'd3), e(3'b111, 2'd3), e(3'd0, 2'd1), e(3'd1, 2'd1)};
    for (int i = 0; i < 8; i++) begin
      drive(st[i], ex[i]);
      xp  = exp_q.pop_front();
      got = {seg_sel, state_o, busy, err};
      n_checks++;
      if (got !== xp) begin
        n_fail++;
        $display("FAIL out_of_order[%0d] got=%b exp=%b", i, got, xp);
      end
    end
  endtask

  // Starts in RUN with last count 1.
  task automatic test_simultaneous();
    logic [6:0] got;
    logic [6:0] xp;
    logic [4:0] st [9];
    logic [6:0] ex [9];
    st = '{S2, S3 | 5'b00001, NONE, 5'b11011, S1, 5'b11011, S1,
           S3 | 5'b00001, START};
    ex = '{e(3'd2, 2'd1), e(3'd3, 2'd2), e(3'd3, 2'd2), e(3'd0, 2'd1),
           e(3'd1, 2'd1), e(3'd0, 2'd1), e(3'd1, 2'd1), e(3'b111, 2'd3),
           e(3'd0, 2'd1)};
    for (int i = 0; i < 9; i++) begin
      drive(st[i], ex[i]);
      xp  = exp_q.pop_front();
      got = {seg_sel, state_o, busy, err};
      n_checks++;
      if (got !== xp) begin
        n_fail++;
        $display("FAIL simultaneous[%0d] got=%b exp=%b", i, got, xp);
      end
    end
  endtask

  // Starts in RUN with last count 0.
  task automatic test_wrap();
    logic [6:0] got;
    logic [6:0] xp;
    logic [4:0] st [10];
    logic [6:0] ex [10];
    st = '{S1, S2, S3, S0, S1, S2 | 5'b00001, START, S1, DONE_I, NONE};
    ex = '{e(3'd1, 2'd1), e(3'd2, 2'd1), e(3'd3, 2'd1), e(3'd0, 2'd1),
           e(3'd1, 2'd1), e(3'd2, 2'd2), e(3'd0, 2'd1), e(3'd1, 2'd1),
           e(3'd1, 2'd2), e(3'd1, 2'd2)};
    for (int i = 0; i < 10; i++) begin
      drive(st[i], ex[i]);
      xp  = exp_q.pop_front();
      got = {seg_sel, state_o, busy, err};
      n_checks++;
      if (got !== xp) begin
        n_fail++;
        $display("FAIL wrap[%0d] got=%b exp=%b", i, got, xp);
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_normal_run();
    test_blink_timeout();
    test_out_of_order();
    test_simultaneous();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_display_controller.md
Name: mult_display_controller

Overview:
- Sequencer for the 3-bit seven-segment encoder input of the 8x8 sequential multiplier.
- Tracks the multiplier's 2-bit step counter through a run and presents codes 0..3 to the encoder.
- Blinks the final step after completion, then times out to blank.
- Flags out-of-order step counts with a dedicated error code.

Parameters:
- BLINK_DIV, 4: half-period of the DONE blink, in clock cycles (>=1).
- HOLD_CYCLES, 16: cycles spent in DONE before returning to IDLE (>=1).
- BLANK_CODE, 3'b100: encoder code shown when the display is blank (invalid range 4..6).
- ERR_CODE, 3'b111: encoder code shown in the error state.

Ports:
- clk  input  1  system clock, rising edge.
- reset_a  input  1  asynchronous, active-low reset.
- start  input  1  multiplier start pulse; begins or restarts a run.
- step_en  input  1  multiplier advanced its counter this cycle.
- count  input  2  multiplier step counter value, valid when step_en=1.
- done  input  1  multiplier completion flag.
- seg_sel  output  3  code driven to the seven-segment encoder input.
- busy  output  1  high in RUN.
- err  output  1  high in ERR.
- state_o  output  2  encoded FSM state: IDLE=0, RUN=1, DONE=2, ERR=3.

Behaviour:
- All outputs are registered. Every input takes effect on seg_sel one clock later.
- Reset (reset_a=0, asynchronous), applied immediately and held until release:
  - state=IDLE, seg_sel=BLANK_CODE, busy=0, err=0.
  - last_cnt=0, blink/hold counters=0, blink phase=on.
- Priority in every state: start > step_en > done.
- IDLE:
  - seg_sel=BLANK_CODE.
  - start -> RUN with seg_sel=3'b000 and last_cnt=0.
  - step_en and done are ignored.
- RUN (busy=1):
  - step_en with count==last_cnt+1 (mod 4): last_cnt<=count and seg_sel<={1'b0,count}.
  - step_en with any other count: -> ERR, seg_sel=ERR_CODE, err=1.
  - done=1:
    - Goes to DONE next cycle.
    - If step_en is high in the same cycle, the valid step is applied first and DONE shows the updated count.
    - A bad step in that cycle goes to ERR instead.
    - Blink/hold counters cleared; phase=on; seg_sel={1'b0,last_cnt}.
  - start while in RUN restarts: seg_sel=0, last_cnt=0, stays in RUN.
- DONE:
  - Blink counter increments each cycle.
  - At BLINK_DIV-1 the counter wraps to 0 and the phase toggles.
    - phase on: seg_sel={1'b0,last_cnt}.
    - phase off: seg_sel=BLANK_CODE.
  - Hold counter increments each cycle. At HOLD_CYCLES-1 -> IDLE with seg_sel=BLANK_CODE.
  - step_en and done are ignored.
  - start -> RUN, exactly as from IDLE.
- ERR:
  - seg_sel=ERR_CODE and err=1, held indefinitely.
  - Only start (-> RUN, err=0) or reset leaves ERR.
- Counter widths: clog2 of the parameter, minimum 1 bit. Counters never exceed parameter-1.
- Count wrap: 3 -> 0 is a legal step.
- Mid-operation reset: returns to the reset values immediately, regardless of state.

Test Plan:
- Reset: drive reset_a=0 during RUN. Required: seg_sel=3'b100, state_o=0, busy=0, err=0 with no clock edge; values hold after release.
- Normal run: start; then step_en with count=1, 2, 3 on consecutive cycles; then done. Required: seg_sel=0,1,2,3 each one cycle later; state_o=2.
- Blink/timeout with defaults: seg_sel alternates 3 (4 cycles) / 3'b100 (4 cycles). After 16 DONE cycles, state_o=0 and seg_sel=3'b100.
- Out-of-order step: in RUN with last_cnt=1, step_en with count=3. Required: next cycle seg_sel=3'b111, err=1, state_o=3. Further step_en/done are ignored; start recovers with seg_sel=0.
- Simultaneous events:
  - step_en(count=3) with done at last_cnt=2: DONE showing 3.
  - start with step_en and done in RUN: restart, seg_sel=0, state_o=1.
- Wrap: last_cnt=3, step_en with count=0 -> seg_sel=0, no error.
